// File: rtl/lidar_pkg.sv
// rtl/lidar_pkg.sv - point word layout and packing helper for the LiDAR receiver
package lidar_pkg;

    localparam int POINT_W   = 48;
    localparam int DIST_LSB  = 0;
    localparam int DIST_W    = 16;
    localparam int ANGLE_LSB = 16;
    localparam int ANGLE_W   = 16;
    localparam int LASER_LSB = 32;
    localparam int LASER_W   = 8;
    localparam int INTEN_LSB = 40;
    localparam int INTEN_W   = 8;

    typedef struct packed {
        logic               last;
        logic [POINT_W-1:0] word;
    } entry_t;

    function automatic logic [POINT_W-1:0] pack_point(
        input logic [DIST_W-1:0]  distance,
        input logic [ANGLE_W-1:0] angle,
        input logic [LASER_W-1:0] laser_num,
        input logic [INTEN_W-1:0] intensity
    );
        logic [POINT_W-1:0] p;
        p = '0;
        p[DIST_LSB  +: DIST_W]  = distance;
        p[ANGLE_LSB +: ANGLE_W] = angle;
        p[LASER_LSB +: LASER_W] = laser_num;
        p[INTEN_LSB +: INTEN_W] = intensity;
        return p;
    endfunction

endpackage

// File: rtl/point_fifo.sv
// rtl/point_fifo.sv - synchronous show-ahead FIFO with extended-pointer full/empty
module point_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    // full is taken before any same-cycle pop, so a pop never makes room for a push
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/lidar_point_receiver.sv
// rtl/lidar_point_receiver.sv - range-gated point staging, buffering and frame stats; RANGE_GATE_EN enables the distance gate
module lidar_point_receiver
    import lidar_pkg::*;
#(
    parameter int          DEPTH    = 512,
    parameter logic [15:0] MIN_DIST = 16'd1,
    parameter logic [15:0] MAX_DIST = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_frame,
    input  logic [15:0]        in_distance,
    input  logic [15:0]        in_angle,
    input  logic [7:0]         in_laser_num,
    input  logic [7:0]         in_intensity,
    output logic [POINT_W-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic [15:0]        frame_count,
    output logic [15:0]        frame_points,
    output logic [15:0]        drop_count,
    output logic               overflow
);

    logic               accept;
    logic               stg_valid, stg_valid_n;
    logic               stg_last, stg_last_n;
    logic [POINT_W-1:0] stg_word, stg_word_n;
    logic               stg_last_eff;
    logic               push, push_last, drop;
    logic               fifo_full;
    logic [15:0]        run_count;
    entry_t             wr_entry, rd_entry;

`ifdef RANGE_GATE_EN
    assign accept = in_valid && (in_distance >= MIN_DIST) && (in_distance <= MAX_DIST);
`else
    logic unused_gate;
    assign unused_gate = ^{MIN_DIST, MAX_DIST};
    assign accept      = in_valid;
`endif

    // a frame pulse closes whatever is already staged, never the point arriving with it
    assign stg_last_eff = stg_last || in_frame;

    always_comb begin
        stg_valid_n = stg_valid;
        stg_last_n  = stg_last;
        stg_word_n  = stg_word;
        push        = 1'b0;
        push_last   = 1'b0;
        drop        = 1'b0;
        if (accept) begin
            if (!stg_valid) begin
                stg_valid_n = 1'b1;
                stg_last_n  = 1'b0;
                stg_word_n  = pack_point(in_distance, in_angle, in_laser_num, in_intensity);
            end else if (!fifo_full) begin
                push        = 1'b1;
                push_last   = stg_last_eff;
                stg_last_n  = 1'b0;
                stg_word_n  = pack_point(in_distance, in_angle, in_laser_num, in_intensity);
            end else begin
                drop        = 1'b1;
                stg_last_n  = stg_last_eff;
            end
        end else if (stg_valid) begin
            if (stg_last_eff && !fifo_full) begin
                push        = 1'b1;
                push_last   = 1'b1;
                stg_valid_n = 1'b0;
                stg_last_n  = 1'b0;
            end else begin
                stg_last_n  = stg_last_eff;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid    <= 1'b0;
            stg_last     <= 1'b0;
            stg_word     <= '0;
            run_count    <= '0;
            frame_count  <= '0;
            frame_points <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            stg_valid <= stg_valid_n;
            stg_last  <= stg_last_n;
            stg_word  <= stg_word_n;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            if (in_frame) begin
                frame_count  <= frame_count + 16'd1;
                frame_points <= (push && run_count != 16'hFFFF) ? run_count + 16'd1 : run_count;
                run_count    <= '0;
            end else if (push && run_count != 16'hFFFF) begin
                run_count <= run_count + 16'd1;
            end
        end
    end

    assign wr_entry.last = push_last;
    assign wr_entry.word = stg_word;

    point_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (push),
        .wr_data  (wr_entry),
        .full     (fifo_full),
        .rd_en    (m_ready),
        .rd_data  (rd_entry),
        .rd_valid (m_valid)
    );

    assign m_data = rd_entry.word;
    assign m_last = rd_entry.last;

endmodule

// File: tb/tb_lidar_point_receiver.sv
// tb/tb_lidar_point_receiver.sv - directed self-checking bench for lidar_point_receiver
module tb_lidar_point_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_frame;
    logic [15:0] in_distance, in_angle;
    logic [7:0]  in_laser_num, in_intensity;
    logic [47:0] m_data;
    logic        m_valid, m_ready, m_last;
    logic [15:0] frame_count, frame_points, drop_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    logic [48:0] got[$];
    logic [48:0] exp_q[$];

    lidar_point_receiver #(
        .DEPTH    (4),
        .MIN_DIST (16'd50),
        .MAX_DIST (16'd1000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_frame     (in_frame),
        .in_distance  (in_distance),
        .in_angle     (in_angle),
        .in_laser_num (in_laser_num),
        .in_intensity (in_intensity),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_last       (m_last),
        .frame_count  (frame_count),
        .frame_points (frame_points),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready) got.push_back({m_last, m_data});
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [48:0] exp_word(input logic [15:0] d, input logic last);
        logic [15:0] a;
        a = d ^ 16'h5A5A;
        return {last, d[7:0], 8'd7, a, d};
    endfunction

    task automatic drive(input logic v, input logic f, input logic [15:0] d);
        @(posedge clk);
        #1;
        in_valid     = v;
        in_frame     = f;
        in_distance  = d;
        in_angle     = d ^ 16'h5A5A;
        in_laser_num = 8'd7;
        in_intensity = d[7:0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'd0);
    endtask

    task automatic compare_words(input string tag);
        check_val({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check_val($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        m_ready = 1'b1;
        in_valid = 1'b0; in_frame = 1'b0; in_distance = '0;
        in_angle = '0; in_laser_num = '0; in_intensity = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_m_valid", m_valid, 1'b0);
        check_val("rst_m_data", m_data, 48'd0);
        check_val("rst_frame_count", frame_count, 16'd0);
        check_val("rst_drop_count", drop_count, 16'd0);
        check_val("rst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // three points then a frame end
        drive(1, 0, 16'd100); drive(1, 0, 16'd200); drive(1, 0, 16'd300);
        drive(0, 1, 16'd0); idle(8);
        exp_q.push_back(exp_word(16'd100, 0));
        exp_q.push_back(exp_word(16'd200, 0));
        exp_q.push_back(exp_word(16'd300, 1));
        compare_words("basic");
        check_val("basic_frame_count", frame_count, 16'd1);
        check_val("basic_frame_points", frame_points, 16'd3);

        // empty frame
        drive(0, 1, 16'd0); idle(6);
        compare_words("empty");
        check_val("empty_frame_count", frame_count, 16'd2);
        check_val("empty_frame_points", frame_points, 16'd0);

        // range gate boundaries
        drive(1, 0, 16'd0); drive(1, 0, 16'd49); drive(1, 0, 16'd50);
        drive(1, 0, 16'd1000); drive(1, 0, 16'd1001);
        drive(0, 1, 16'd0); idle(10);
`ifdef RANGE_GATE_EN
        exp_q.push_back(exp_word(16'd50, 0));
        exp_q.push_back(exp_word(16'd1000, 1));
        check_val("gate_frame_points", frame_points, 16'd2);
`else
        exp_q.push_back(exp_word(16'd0, 0));
        exp_q.push_back(exp_word(16'd49, 0));
        exp_q.push_back(exp_word(16'd50, 0));
        exp_q.push_back(exp_word(16'd1000, 0));
        exp_q.push_back(exp_word(16'd1001, 1));
        check_val("gate_frame_points", frame_points, 16'd5);
`endif
        compare_words("gate");
        check_val("gate_drop_count", drop_count, 16'd0);
        check_val("gate_frame_count", frame_count, 16'd3);

        // point and frame end in the same cycle
        drive(1, 0, 16'd100); drive(1, 1, 16'd200); idle(3);
        check_val("same_frame_points_a", frame_points, 16'd1);
        drive(0, 1, 16'd0); idle(6);
        exp_q.push_back(exp_word(16'd100, 1));
        exp_q.push_back(exp_word(16'd200, 1));
        compare_words("same");
        check_val("same_frame_points_b", frame_points, 16'd1);
        check_val("same_frame_count", frame_count, 16'd5);

        // overflow with consumer stalled
        m_ready = 1'b0;
        for (int k = 0; k < 10; k++) drive(1, 0, 16'd100 + 16'(k));
        drive(0, 1, 16'd0); idle(4);
        check_val("ovf_drop_count", drop_count, 16'd5);
        check_val("ovf_overflow", overflow, 1'b1);
        check_val("ovf_frame_points", frame_points, 16'd4);
        check_val("ovf_head", {m_valid, m_last, m_data}, {1'b1, exp_word(16'd100, 0)});
        idle(3);
        check_val("ovf_head_stable", {m_valid, m_last, m_data}, {1'b1, exp_word(16'd100, 0)});
        @(posedge clk); #1; m_ready = 1'b1;
        idle(12);
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_word(16'd100 + 16'(k), k == 4));
        compare_words("ovf");
        check_val("ovf_empty", m_valid, 1'b0);

        // asynchronous reset with words buffered
        m_ready = 1'b0;
        drive(1, 0, 16'd300); drive(1, 0, 16'd400); drive(1, 0, 16'd500);
        drive(0, 1, 16'd0); idle(3);
        check_val("arst_pre_valid", m_valid, 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_m_valid", m_valid, 1'b0);
        check_val("arst_counters", {frame_count, frame_points, drop_count}, 48'd0);
        check_val("arst_overflow", overflow, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        check_val("arst_post_valid", m_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
